// File: rtl/db_rr_sched_pkg.sv
// Shared types, constants and helpers for the doorbell round-robin scheduler.
package db_rr_sched_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    localparam logic DB_TYPE_SQ = 1'b0;
    localparam logic DB_TYPE_CQ = 1'b1;

    localparam int unsigned VAL_W = 32;
    localparam int unsigned DB_W  = 64;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned log2ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/db_rr_sched_if.sv
// Doorbell bus: per-channel SQ/CQ doorbell inputs and the single PIO doorbell output.
interface db_rr_sched_if #(
    parameter int unsigned DQ_CH = 4
);
    logic        sqdb_valid_ch [DQ_CH];
    logic [63:0] sqdb_tail_ch  [DQ_CH];
    logic        sqdb_ready_ch [DQ_CH];
    logic        cqdb_valid_ch [DQ_CH];
    logic [63:0] cqdb_head_ch  [DQ_CH];
    logic        cqdb_ready_ch [DQ_CH];
    logic        db_valid;
    logic        db_type;
    logic [63:0] db_data;
    logic        db_ready;
    logic [31:0] coalesce_cnt;

    // Scheduler side.
    modport slave (
        input  sqdb_valid_ch, sqdb_tail_ch, cqdb_valid_ch, cqdb_head_ch, db_ready,
        output sqdb_ready_ch, cqdb_ready_ch, db_valid, db_type, db_data, coalesce_cnt
    );

    // Environment side: doorbell writers and PIO consumer.
    modport master (
        output sqdb_valid_ch, sqdb_tail_ch, cqdb_valid_ch, cqdb_head_ch, db_ready,
        input  sqdb_ready_ch, cqdb_ready_ch, db_valid, db_type, db_data, coalesce_cnt
    );
endinterface

// File: rtl/db_rr_sched_pick.sv
// Round-robin picker: first pending source strictly after last_grant, wrapping.
module db_rr_pick #(
    parameter int unsigned NSRC  = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [NSRC-1:0]  pending_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] idx_v;

    // Scan offsets from farthest to nearest so the nearest pending source wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx_v         = '0;
        for (int unsigned off = NSRC; off >= 1; off--) begin
            idx_v = IDX_W'((32'(last_grant_i) + off) % NSRC);
            if (pending_i[idx_v]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx_v;
            end
        end
    end

endmodule

// File: rtl/db_rr_sched.sv
// Doorbell scheduler: coalesces SQ/CQ doorbells per source and issues them
// one per cycle to the PIO in round-robin order.
module db_rr_sched
    import db_rr_sched_pkg::*;
#(
    parameter int unsigned DQ_CH  = 4,
    parameter int unsigned DQ_IDX = log2ceil(DQ_CH)
) (
    input logic          axi4_mm_clk,
    input logic          axi4_mm_rst,
    db_rr_sched_if.slave bus
);

    localparam int unsigned NSRC  = 2 * DQ_CH;
    localparam int unsigned SRC_W = log2ceil(NSRC);
    localparam int unsigned CNT_W = log2ceil(NSRC + 1);
    localparam int unsigned PAD_W = VAL_W - DQ_IDX;

    state_e             state_q, state_d;
    logic [NSRC-1:0]    pending_q, pending_d;
    logic [VAL_W-1:0]   value_q [NSRC];
    logic [VAL_W-1:0]   value_d [NSRC];
    logic [SRC_W-1:0]   last_grant_q;
    logic               db_valid_q;
    logic               db_type_q;
    logic [DB_W-1:0]    db_data_q;
    logic [31:0]        coalesce_q;

    logic [NSRC-1:0]    acc_c;
    logic [VAL_W-1:0]   wr_val_c [NSRC];
    logic               grant_valid_c;
    logic [SRC_W-1:0]   grant_idx_c;
    logic               grant_en_c;
    logic [CNT_W-1:0]   coal_n_c;
    logic [SRC_W-1:0]   chan_full_c;
    logic [DB_W-1:0]    db_data_c;
    logic               hit_c;
    logic               unused_hi_c;

    // Doorbells are always accepted outside reset.
    for (genvar g = 0; g < DQ_CH; g++) begin : g_rdy
        assign bus.sqdb_ready_ch[g] = ~axi4_mm_rst;
        assign bus.cqdb_ready_ch[g] = ~axi4_mm_rst;
    end

    assign bus.db_valid     = db_valid_q;
    assign bus.db_type      = db_type_q;
    assign bus.db_data      = db_data_q;
    assign bus.coalesce_cnt = coalesce_q;

    // Flatten SQ then CQ channels into one source space; upper halves are don't-care.
    always_comb begin
        acc_c       = '0;
        unused_hi_c = 1'b0;
        for (int i = 0; i < int'(DQ_CH); i++) begin
            acc_c[i]             = bus.sqdb_valid_ch[i];
            acc_c[DQ_CH + i]     = bus.cqdb_valid_ch[i];
            wr_val_c[i]          = bus.sqdb_tail_ch[i][VAL_W-1:0];
            wr_val_c[DQ_CH + i]  = bus.cqdb_head_ch[i][VAL_W-1:0];
            unused_hi_c          = unused_hi_c ^ (^bus.sqdb_tail_ch[i][63:32])
                                               ^ (^bus.cqdb_head_ch[i][63:32]);
        end
    end

    db_rr_pick #(
        .NSRC  (NSRC),
        .IDX_W (SRC_W)
    ) u_pick (
        .pending_i     (pending_q),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid_c),
        .grant_idx_o   (grant_idx_c)
    );

    // Next state and grant enable.
    always_comb begin
        state_d    = state_q;
        grant_en_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_valid_c) begin
                    grant_en_c = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.db_ready) begin
                    if (grant_valid_c) begin
                        grant_en_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-source pending/value update; a write to the source being granted is not a coalesce.
    always_comb begin
        pending_d = pending_q;
        value_d   = value_q;
        coal_n_c  = '0;
        hit_c     = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            hit_c = grant_en_c && (grant_idx_c == SRC_W'(i));
            if (acc_c[i]) begin
                pending_d[i] = 1'b1;
                value_d[i]   = wr_val_c[i];
                if (pending_q[i] && !hit_c) begin
                    coal_n_c = coal_n_c + CNT_W'(1);
                end
            end else if (hit_c) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Encode the granted source: channel in the top bits, value in the low word.
    always_comb begin
        chan_full_c = (grant_idx_c >= SRC_W'(DQ_CH)) ? grant_idx_c - SRC_W'(DQ_CH) : grant_idx_c;
        db_data_c   = {DQ_IDX'(chan_full_c), PAD_W'(0), value_q[grant_idx_c]};
    end

    // Control state, pending bits, output register and coalesce counter.
    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            last_grant_q <= SRC_W'(NSRC - 1);
            db_valid_q   <= 1'b0;
            db_type_q    <= DB_TYPE_SQ;
            db_data_q    <= '0;
            coalesce_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            db_valid_q <= (state_d == S_ISSUE);
            coalesce_q <= coalesce_q + 32'(coal_n_c);
            if (grant_en_c) begin
                last_grant_q <= grant_idx_c;
                db_type_q    <= (grant_idx_c >= SRC_W'(DQ_CH)) ? DB_TYPE_CQ : DB_TYPE_SQ;
                db_data_q    <= db_data_c;
            end
        end
    end

    // Value storage needs no reset; it is only read behind a pending bit.
    always_ff @(posedge axi4_mm_clk) begin
        value_q <= value_d;
    end

endmodule

// File: doc/db_rr_sched.md
DB_RR_SCHED -- requirements
Module: db_rr_sched

Interface
REQ-001 SHALL have parameter DQ_CH, default 4, meaning number of doorbell channels (at least 2).
REQ-002 SHALL have parameter DQ_IDX, default log2ceil(DQ_CH), meaning channel index width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port axi4_mm_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port axi4_mm_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port sqdb_valid_ch[DQ_CH], input, 1 bit each: SQ tail doorbell write from each channel.
REQ-007 SHALL have port sqdb_tail_ch[DQ_CH], input, 64 bits each: SQ tail value; only bits [31:0] are used.
REQ-008 SHALL have port sqdb_ready_ch[DQ_CH], output, 1 bit each: SQ doorbell accept.
REQ-009 SHALL have ports cqdb_valid_ch, cqdb_head_ch and cqdb_ready_ch, with the same shapes as the SQ ports, for CQ head doorbells.
REQ-010 SHALL have port db_valid, output, 1 bit: doorbell offered to the PIO.
REQ-011 SHALL have port db_type, output, 1 bit: 0 = SQ, 1 = CQ.
REQ-012 SHALL have port db_data, output, 64 bits: encoded doorbell.
REQ-013 SHALL have port db_ready, input, 1 bit: PIO accept.
REQ-014 SHALL have port coalesce_cnt, output, 32 bits: count of overwritten (coalesced) doorbells.

Function
REQ-015 SHALL keep 2*DQ_CH sources: SQ0..SQ(DQ_CH-1) at indices 0..DQ_CH-1, then CQ0..CQ(DQ_CH-1) at indices DQ_CH..2*DQ_CH-1.
REQ-016 SHALL keep, per source, a pending bit and a 32-bit value register.
REQ-017 SHALL hold sqdb_ready_ch and cqdb_ready_ch high in every cycle except reset; a doorbell is accepted whenever valid is high.
REQ-018 On accept, SHALL write the source's value register with the input [31:0] and set its pending bit, both visible the next cycle.
REQ-019 SHALL increment coalesce_cnt by 1 when a source is accepted while its pending bit is already set and that source is not granted in the same cycle.
REQ-020 coalesce_cnt SHALL increment by the number of such sources when several coalesce in the same cycle, and SHALL wrap at 2^32.
REQ-021 The state machine SHALL have two states, S_IDLE and S_ISSUE.
REQ-022 In S_IDLE with any pending source: SHALL grant the first pending source after last_grant in round-robin order, register the output fields, clear that source's pending bit, update last_grant, and go to S_ISSUE.
REQ-023 In S_IDLE with no pending source, SHALL stay in S_IDLE.
REQ-024 In S_ISSUE, db_valid SHALL be 1, and db_type and db_data SHALL be stable until the cycle in which db_ready is high.
REQ-025 On a handshake in S_ISSUE with another source pending, SHALL grant that source in the same cycle (back-to-back, one doorbell per cycle) and stay in S_ISSUE.
REQ-026 On a handshake in S_ISSUE with nothing pending, SHALL go to S_IDLE with db_valid 0 the next cycle.
REQ-027 db_data SHALL be {channel[DQ_IDX-1:0], (32-DQ_IDX) zeros, value[31:0]}, where channel = source index mod DQ_CH.
REQ-028 db_type SHALL be 1 when the source index is DQ_CH or above, else 0.
REQ-029 Latency SHALL be: accept in cycle N, pending in N+1, db_valid high in N+2 when idle and uncontended.
REQ-030 If a source is accepted in the cycle it is granted: the output SHALL carry the old value, the pending bit SHALL stay set with the new value, and coalesce_cnt SHALL NOT increment.
REQ-031 The round-robin SHALL be fair: a pending source SHALL be granted within 2*DQ_CH grants.

Reset
REQ-032 On reset: db_valid, db_type and db_data SHALL be 0.
REQ-033 On reset: all pending bits SHALL be 0, coalesce_cnt SHALL be 0 and the state SHALL be S_IDLE.
REQ-034 On reset: last_grant SHALL be 2*DQ_CH-1, so SQ0 wins first.
REQ-035 sqdb_ready_ch and cqdb_ready_ch SHALL be 0 during reset.
REQ-036 Reset asserted mid-offer SHALL drop the offered and all pending doorbells, with db_valid 0 in the cycle after reset is sampled.

Structure
REQ-037 A shared package SHALL hold the state enum (S_IDLE, S_ISSUE), the DB_TYPE_SQ/DB_TYPE_CQ constants and the log2ceil function.
REQ-038 The round-robin pick SHALL be one sub-module, db_rr_pick: inputs are the pending vector and last_grant; outputs are grant_valid and grant_idx, purely combinational.

Verification
REQ-039 Bench SHALL cover: reset, then SQ1 tail 0x10 -> two cycles later db_valid=1, db_type=0, db_data=0x4000_0000_0000_0010 (DQ_CH=4).
REQ-040 Bench SHALL cover: SQ0, SQ2 and CQ3 written in the same cycle with db_ready held 1 -> grants SQ0, SQ2, CQ3 on consecutive cycles; the CQ3 db_data is 0xC000_0000_0000_00xx.
REQ-041 Bench SHALL cover: db_ready=0 while CQ0 is written 5, 6, 7 -> one doorbell with value 7 and coalesce_cnt=2.
REQ-042 Bench SHALL cover: db_ready stalled for 10 cycles -> db_valid, db_type and db_data stable throughout.
REQ-043 Bench SHALL cover: all 8 sources pending continuously -> each granted exactly once per 8 handshakes.
REQ-044 Bench SHALL cover: reset pulsed while db_valid=1 and 3 sources are pending -> db_valid=0 and nothing issued afterward.
